// File: rtl/brc_if.sv
// Operand/flag bundle for the branch comparator.
// Latency: wires only; the comparator defines all timing.
// Backpressure: none; operands are sampled every cycle, flags always valid.
//
// Signals:
//   i_rs1_data   32  operand A (rs1), driven by the issuing stage
//   i_rs2_data   32  operand B (rs2), driven by the issuing stage
//   i_br_un       1  1 = unsigned compare, 0 = signed compare
//   o_br_less     1  A < B under the selected mode, combinational
//   o_br_equal    1  A == B bitwise, combinational
//   o_br_less_q   1  o_br_less registered on the core clock
//   o_br_equal_q  1  o_br_equal registered on the core clock
interface brc_if;
    logic [31:0] i_rs1_data;
    logic [31:0] i_rs2_data;
    logic        i_br_un;
    logic        o_br_less;
    logic        o_br_equal;
    logic        o_br_less_q;
    logic        o_br_equal_q;

    // Source of operands: branch control / execute stage.
    modport master (
        output i_rs1_data,
        output i_rs2_data,
        output i_br_un,
        input  o_br_less,
        input  o_br_equal,
        input  o_br_less_q,
        input  o_br_equal_q
    );

    // The comparator itself.
    modport slave (
        input  i_rs1_data,
        input  i_rs2_data,
        input  i_br_un,
        output o_br_less,
        output o_br_equal,
        output o_br_less_q,
        output o_br_equal_q
    );
endinterface

// File: rtl/brc.sv
// RV32I branch comparator: less-than (signed/unsigned) and equality flags.
// Latency: flags are combinational (0 cycles); the _q copies lag by 1 cycle.
// Backpressure: none; a new operand pair is accepted every cycle.
//
// Ports:
//   i_clk    rising-edge clock for the registered flag copies
//   i_rst_n  asynchronous active-low reset, clears only the registered flags
//   bus      brc_if.slave carrying operands, mode select and all four flags
module brc (
    input  logic   i_clk,
    input  logic   i_rst_n,
    brc_if.slave   bus
);

    // ------------------------------------------------------------------
    // Operand conditioning
    // ------------------------------------------------------------------
    // A - B is formed as A + ~B + 1, so the adder sees the inverted B.
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] op_b_n;

    assign op_a   = bus.i_rs1_data;
    assign op_b   = bus.i_rs2_data;
    assign op_b_n = ~op_b;

    // ------------------------------------------------------------------
    // Carry chain of A + ~B + 1
    // ------------------------------------------------------------------
    // Only the carry-out (bit 32 of the 33-bit difference) matters, so the
    // sum bits are never built. The chain is split into eight 4-bit
    // lookahead groups with a ripple between groups, which keeps the
    // critical path short without a full prefix tree.
    logic [31:0] bit_gen;
    logic [31:0] bit_prop;
    logic [7:0]  grp_gen;
    logic [7:0]  grp_prop;
    logic        sub_carry;

    always_comb begin
        logic carry;

        bit_gen  = op_a & op_b_n;
        // OR-propagate is sufficient for the carry path (XOR is only
        // needed for sum bits).
        bit_prop = op_a | op_b_n;

        grp_gen  = '0;
        grp_prop = '0;
        for (int k = 0; k < 8; k++) begin
            grp_gen[k] = bit_gen[4*k+3]
                       | (bit_prop[4*k+3] & bit_gen[4*k+2])
                       | (bit_prop[4*k+3] & bit_prop[4*k+2] & bit_gen[4*k+1])
                       | (bit_prop[4*k+3] & bit_prop[4*k+2] & bit_prop[4*k+1]
                          & bit_gen[4*k]);
            grp_prop[k] = &bit_prop[4*k +: 4];
        end

        // The "+1" of the two's-complement negation enters as carry-in.
        carry = 1'b1;
        for (int k = 0; k < 8; k++) begin
            carry = grp_gen[k] | (grp_prop[k] & carry);
        end
        sub_carry = carry;
    end

    // ------------------------------------------------------------------
    // Equality: XOR per bit, NOR across the word
    // ------------------------------------------------------------------
    logic [31:0] bit_diff;
    logic [7:0]  grp_diff;
    logic        br_equal;

    always_comb begin
        bit_diff = op_a ^ op_b;
        grp_diff = '0;
        for (int k = 0; k < 8; k++) begin
            grp_diff[k] = |bit_diff[4*k +: 4];
        end
        br_equal = ~|grp_diff;
    end

    // ------------------------------------------------------------------
    // Less-than selection
    // ------------------------------------------------------------------
    // No carry-out means the subtraction borrowed, i.e. A < B unsigned.
    // For signed operands with differing signs the unsigned result is
    // inverted, so the answer is simply "A is the negative one".
    logic sign_differ;
    logic br_less;

    always_comb begin
        sign_differ = op_a[31] ^ op_b[31];
        if (!bus.i_br_un && sign_differ) begin
            br_less = op_a[31];
        end else begin
            br_less = ~sub_carry;
        end
    end

    assign bus.o_br_less  = br_less;
    assign bus.o_br_equal = br_equal;

    // ------------------------------------------------------------------
    // Registered copies for the following stage
    // ------------------------------------------------------------------
    logic br_less_d;
    logic br_less_q;
    logic br_equal_d;
    logic br_equal_q;

    always_comb begin
        br_less_d  = br_less;
        br_equal_d = br_equal;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            br_less_q  <= 1'b0;
            br_equal_q <= 1'b0;
        end else begin
            br_less_q  <= br_less_d;
            br_equal_q <= br_equal_d;
        end
    end

    assign bus.o_br_less_q  = br_less_q;
    assign bus.o_br_equal_q = br_equal_q;

endmodule

// File: tb/tb_brc.sv
// Self-checking bench for the branch comparator.
// Latency: checks comb flags 1 time unit after a drive, _q flags after the edge.
// Backpressure: not applicable; operands change freely every cycle.
module tb_brc;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b1;

    brc_if bus ();

    brc dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    int checks   = 0;
    int failures = 0;

    // Reference: the language's own signed/unsigned relational operators.
    function automatic logic ref_less(input logic [31:0] a, input logic [31:0] b,
                                      input logic un);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (un) return (a < b);
        return (sa < sb);
    endfunction

    function automatic logic ref_equal(input logic [31:0] a, input logic [31:0] b);
        return (a == b);
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic un);
        bus.i_rs1_data = a;
        bus.i_rs2_data = b;
        bus.i_br_un    = un;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        drive(32'h0, 32'h0, 1'b0);
        #1 i_rst_n = 1'b0;
        #1;
        checks++;
        if (bus.o_br_less_q !== 1'b0 || bus.o_br_equal_q !== 1'b0) begin
            failures++;
            $display("FAIL reset_q less_q=%b equal_q=%b expected 0/0",
                     bus.o_br_less_q, bus.o_br_equal_q);
        end
        // Clock edges while held in reset must not load the flags.
        @(posedge i_clk);
        #1;
        checks++;
        if (bus.o_br_less_q !== 1'b0 || bus.o_br_equal_q !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold_q less_q=%b equal_q=%b expected 0/0",
                     bus.o_br_less_q, bus.o_br_equal_q);
        end
        // Comb path works regardless of reset.
        checks++;
        if (bus.o_br_less !== 1'b0 || bus.o_br_equal !== 1'b1) begin
            failures++;
            $display("FAIL reset_comb less=%b equal=%b expected 0/1",
                     bus.o_br_less, bus.o_br_equal);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_directed();
        logic [31:0] ta [8];
        logic [31:0] tb_ [8];
        logic        tun [8];
        logic        exp_l [8];
        logic        exp_e [8];
        ta[0] = 32'd0;          tb_[0] = 32'd0;          tun[0] = 0; exp_l[0] = 0; exp_e[0] = 1;
        ta[1] = 32'd2;          tb_[1] = 32'd3;          tun[1] = 0; exp_l[1] = 1; exp_e[1] = 0;
        ta[2] = 32'd10;         tb_[2] = 32'd8;          tun[2] = 0; exp_l[2] = 0; exp_e[2] = 0;
        ta[3] = 32'hFFFFFFFF;   tb_[3] = 32'd3;          tun[3] = 1; exp_l[3] = 0; exp_e[3] = 0;
        ta[4] = 32'hFFFFFFFF;   tb_[4] = 32'd3;          tun[4] = 0; exp_l[4] = 1; exp_e[4] = 0;
        ta[5] = 32'h80000000;   tb_[5] = 32'h7FFFFFFF;   tun[5] = 0; exp_l[5] = 1; exp_e[5] = 0;
        ta[6] = 32'h80000000;   tb_[6] = 32'h7FFFFFFF;   tun[6] = 1; exp_l[6] = 0; exp_e[6] = 0;
        ta[7] = 32'hFFFFFFFF;   tb_[7] = 32'h00000000;   tun[7] = 0; exp_l[7] = 1; exp_e[7] = 0;
        for (int i = 0; i < 8; i++) begin
            drive(ta[i], tb_[i], tun[i]);
            #1;
            checks++;
            if (bus.o_br_less !== exp_l[i] || bus.o_br_equal !== exp_e[i]) begin
                failures++;
                $display("FAIL directed_%0d a=%h b=%h un=%b less=%b equal=%b expected %b/%b",
                         i, ta[i], tb_[i], tun[i], bus.o_br_less, bus.o_br_equal,
                         exp_l[i], exp_e[i]);
            end
        end
        // 0xFFFFFFFF vs 0 unsigned: not less.
        drive(32'hFFFFFFFF, 32'h0, 1'b1);
        #1;
        checks++;
        if (bus.o_br_less !== 1'b0 || bus.o_br_equal !== 1'b0) begin
            failures++;
            $display("FAIL directed_ffff_0_un less=%b equal=%b expected 0/0",
                     bus.o_br_less, bus.o_br_equal);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_mode_flip();
        logic [31:0] fa [2];
        logic [31:0] fb [2];
        fa[0] = 32'h80000000; fb[0] = 32'h7FFFFFFF;
        fa[1] = 32'hDEADBEEF; fb[1] = 32'hDEADBEEF;
        for (int i = 0; i < 2; i++) begin
            drive(fa[i], fb[i], 1'b0);
            #1;
            checks++;
            if (bus.o_br_less !== ref_less(fa[i], fb[i], 1'b0)
                || bus.o_br_equal !== ref_equal(fa[i], fb[i])) begin
                failures++;
                $display("FAIL flip_signed_%0d less=%b equal=%b expected %b/%b", i,
                         bus.o_br_less, bus.o_br_equal,
                         ref_less(fa[i], fb[i], 1'b0), ref_equal(fa[i], fb[i]));
            end
            bus.i_br_un = 1'b1;
            #1;
            checks++;
            if (bus.o_br_less !== ref_less(fa[i], fb[i], 1'b1)
                || bus.o_br_equal !== ref_equal(fa[i], fb[i])) begin
                failures++;
                $display("FAIL flip_unsigned_%0d less=%b equal=%b expected %b/%b", i,
                         bus.o_br_less, bus.o_br_equal,
                         ref_less(fa[i], fb[i], 1'b1), ref_equal(fa[i], fb[i]));
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_registered();
        // Inputs change on the falling edge so they are stable at rising edges.
        @(negedge i_clk);
        i_rst_n = 1'b0;
        drive(32'd3, 32'd4, 1'b0);
        @(posedge i_clk);
        #1;
        checks++;
        if (bus.o_br_less_q !== 1'b0 || bus.o_br_equal_q !== 1'b0) begin
            failures++;
            $display("FAIL reg_in_reset less_q=%b equal_q=%b expected 0/0",
                     bus.o_br_less_q, bus.o_br_equal_q);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        checks++;
        if (bus.o_br_less_q !== 1'b1 || bus.o_br_equal_q !== 1'b0) begin
            failures++;
            $display("FAIL reg_capture less_q=%b equal_q=%b expected 1/0",
                     bus.o_br_less_q, bus.o_br_equal_q);
        end
        // Reset between edges clears at once; comb flags are untouched.
        #2 i_rst_n = 1'b0;
        #1;
        checks++;
        if (bus.o_br_less_q !== 1'b0 || bus.o_br_equal_q !== 1'b0
            || bus.o_br_less !== 1'b1 || bus.o_br_equal !== 1'b0) begin
            failures++;
            $display("FAIL reg_midreset q=%b/%b comb=%b/%b expected q 0/0 comb 1/0",
                     bus.o_br_less_q, bus.o_br_equal_q, bus.o_br_less, bus.o_br_equal);
        end
        @(negedge i_clk);
        drive(32'd5, 32'd5, 1'b1);
        i_rst_n = 1'b1;
        #1;
        checks++;
        if (bus.o_br_less_q !== 1'b0 || bus.o_br_equal_q !== 1'b0) begin
            failures++;
            $display("FAIL reg_release_wait less_q=%b equal_q=%b expected 0/0",
                     bus.o_br_less_q, bus.o_br_equal_q);
        end
        @(posedge i_clk);
        #1;
        checks++;
        if (bus.o_br_less_q !== 1'b0 || bus.o_br_equal_q !== 1'b1) begin
            failures++;
            $display("FAIL reg_resume less_q=%b equal_q=%b expected 0/1",
                     bus.o_br_less_q, bus.o_br_equal_q);
        end
    endtask

    // ------------------------------------------------------------------
    function automatic logic [31:0] pick_operand();
        logic [31:0] ext [5];
        ext[0] = 32'h00000000;
        ext[1] = 32'h00000001;
        ext[2] = 32'h7FFFFFFF;
        ext[3] = 32'h80000000;
        ext[4] = 32'hFFFFFFFF;
        if ($urandom_range(0, 3) == 0) return ext[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    task automatic test_random();
        int fail_before;
        fail_before = failures;
        for (int i = 0; i < 10000; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic        un;
            logic        el;
            logic        ee;
            a  = pick_operand();
            // Occasionally force equal or near-equal operands.
            case ($urandom_range(0, 7))
                0:       b = a;
                1:       b = a + 32'd1;
                2:       b = a - 32'd1;
                default: b = pick_operand();
            endcase
            un = i[0];
            el = ref_less(a, b, un);
            ee = ref_equal(a, b);
            @(negedge i_clk);
            drive(a, b, un);
            #1;
            checks++;
            if (bus.o_br_less !== el || bus.o_br_equal !== ee) begin
                failures++;
                if (failures - fail_before <= 10)
                    $display("FAIL rand_comb a=%h b=%h un=%b less=%b equal=%b expected %b/%b",
                             a, b, un, bus.o_br_less, bus.o_br_equal, el, ee);
            end
            checks++;
            if ((bus.o_br_less & bus.o_br_equal) !== 1'b0) begin
                failures++;
                if (failures - fail_before <= 10)
                    $display("FAIL rand_exclusive a=%h b=%h less=%b equal=%b expected not both 1",
                             a, b, bus.o_br_less, bus.o_br_equal);
            end
            @(posedge i_clk);
            #1;
            checks++;
            if (bus.o_br_less_q !== el || bus.o_br_equal_q !== ee) begin
                failures++;
                if (failures - fail_before <= 10)
                    $display("FAIL rand_reg a=%h b=%h un=%b less_q=%b equal_q=%b expected %b/%b",
                             a, b, un, bus.o_br_less_q, bus.o_br_equal_q, el, ee);
            end
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        drive(32'h0, 32'h0, 1'b0);
        test_reset();
        test_directed();
        test_mode_flip();
        test_registered();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
